// File: rtl/core_pkg.sv
// Shared widths and FSM state type for the unified instruction/data memory arbiter.
package core_pkg;
   localparam int CORE_ADDR_W = 32;
   localparam int CORE_DATA_W = 32;
   localparam int CORE_BE_W   = CORE_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } arb_state_t;
endpackage

// File: rtl/stall_counter.sv
// Free-running 32-bit count of pipeline stall cycles; wraps silently at 2^32.
module stall_counter (
   input  logic        CLK,
   input  logic        RST,
   input  logic        en,
   output logic [31:0] count
);
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count <= 32'd0;
      end else if (en) begin
         count <= count + 32'd1;
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the fetch port and the load/store port,
// with the data port taking priority, and freezes the pipeline while an access is pending.
module mem_arbiter
   import core_pkg::*;
#(
   parameter int ADDR_W = CORE_ADDR_W,
   parameter int DATA_W = CORE_DATA_W
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                IF_Req,
   input  logic [ADDR_W-1:0]   IF_Addr,
   output logic                IF_Ready,
   output logic [DATA_W-1:0]   IF_Data,
   input  logic                DM_Req,
   input  logic                DM_W_En,
   input  logic [ADDR_W-1:0]   DM_Addr,
   input  logic [DATA_W-1:0]   DM_W_Data,
   input  logic [DATA_W/8-1:0] DM_Byte_En,
   output logic                DM_Ready,
   output logic [DATA_W-1:0]   DM_R_Data,
   output logic                BUS_Req,
   output logic                BUS_W_En,
   output logic [ADDR_W-1:0]   BUS_Addr,
   output logic [DATA_W-1:0]   BUS_W_Data,
   output logic [DATA_W/8-1:0] BUS_Byte_En,
   input  logic                BUS_Ack,
   input  logic [DATA_W-1:0]   BUS_R_Data,
   output logic                Stall_F,
   output logic                Stall_M,
   output logic [31:0]         Stall_Count,
   output arb_state_t          dbg_state
);
   // Handshakes: a requester holds Req and its fields stable until its Ready pulses for
   // one cycle; the bus side holds BUS_Req and fields stable until BUS_Ack is sampled high.
   arb_state_t state;
   logic       if_elig;
   logic       dm_elig;

   // A port is masked in its own Ready cycle so a held Req is not served twice.
   assign if_elig   = IF_Req & ~IF_Ready;
   assign dm_elig   = DM_Req & ~DM_Ready;
   assign Stall_F   = if_elig;
   assign Stall_M   = dm_elig;
   assign dbg_state = state;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         BUS_Req     <= 1'b0;
         BUS_W_En    <= 1'b0;
         BUS_Addr    <= '0;
         BUS_W_Data  <= '0;
         BUS_Byte_En <= '0;
         IF_Ready    <= 1'b0;
         DM_Ready    <= 1'b0;
         IF_Data     <= '0;
         DM_R_Data   <= '0;
      end else begin
         IF_Ready <= 1'b0;
         DM_Ready <= 1'b0;
         case (state)
            IDLE: begin
               if (dm_elig) begin
                  BUS_Req     <= 1'b1;
                  BUS_W_En    <= DM_W_En;
                  BUS_Addr    <= DM_Addr;
                  BUS_W_Data  <= DM_W_Data;
                  BUS_Byte_En <= DM_Byte_En;
                  state       <= DM_BUSY;
               end else if (if_elig) begin
                  BUS_Req     <= 1'b1;
                  BUS_W_En    <= 1'b0;
                  BUS_Addr    <= IF_Addr;
                  BUS_W_Data  <= '0;
                  BUS_Byte_En <= '0;
                  state       <= IF_BUSY;
               end
            end
            IF_BUSY: begin
               if (BUS_Ack) begin
                  BUS_Req  <= 1'b0;
                  IF_Data  <= BUS_R_Data;
                  IF_Ready <= 1'b1;
                  state    <= IDLE;
               end
            end
            DM_BUSY: begin
               if (BUS_Ack) begin
                  BUS_Req  <= 1'b0;
                  if (!BUS_W_En) begin
                     DM_R_Data <= BUS_R_Data;
                  end
                  DM_Ready <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               BUS_Req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   stall_counter u_stall_counter (
      .CLK   (CLK),
      .RST   (RST),
      .en    (Stall_F | Stall_M),
      .count (Stall_Count)
   );
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory bus between the fetch stage's instruction port and the memory stage's load/store port. It sequences each access over a request/acknowledge bus handshake and returns read data to the requester. It drives the stall signals that freeze the pipeline while an access is outstanding. It sits between the core pipeline and the unified memory, and replaces the separate instruction and data memories.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- CLK  in  1  core clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-high
- IF_Req  in  1  fetch request; held with IF_Addr stable until IF_Ready
- IF_Addr  in  ADDR_W  fetch address
- IF_Ready  out  1  one-cycle pulse; IF_Data valid in this cycle
- IF_Data  out  DATA_W  fetched instruction (registered)
- DM_Req  in  1  load/store request; held stable until DM_Ready
- DM_W_En  in  1  1 = store, 0 = load
- DM_Addr  in  ADDR_W  data address
- DM_W_Data  in  DATA_W  store data
- DM_Byte_En  in  DATA_W/8  store byte lanes; ignored for loads
- DM_Ready  out  1  one-cycle pulse; DM_R_Data valid in this cycle (loads)
- DM_R_Data  out  DATA_W  load data (registered)
- BUS_Req  out  1  bus request, registered
- BUS_W_En, BUS_Addr, BUS_W_Data, BUS_Byte_En  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the granted request
- BUS_Ack  in  1  memory completion; BUS_R_Data valid in the same cycle
- BUS_R_Data  in  DATA_W  read data
- Stall_F  out  1  IF_Req & ~IF_Ready (combinational)
- Stall_M  out  1  DM_Req & ~DM_Ready (combinational)
- Stall_Count  out  32  number of cycles with Stall_F | Stall_M; wraps at 2^32

## Operation
- The FSM has three states: IDLE, IF_BUSY, DM_BUSY.
- IDLE arbitrates among eligible requesters. A requester is eligible when its Req is high and its Ready is not high in the current cycle, so a requester is masked in the cycle it receives its Ready pulse.
- Priority is fixed: the data port wins over the fetch port, because the data-side instruction is older.
- On a grant, the request fields are registered onto the bus, BUS_Req is set, and the FSM moves to the matching BUSY state.
- In a BUSY state, BUS_Req and all BUS fields are held constant until BUS_Ack is sampled high.
- On BUS_Ack:
  - BUS_Req is cleared.
  - BUS_R_Data is captured into IF_Data or DM_R_Data. For stores, DM_R_Data is left unchanged.
  - The matching Ready is registered high for the next cycle only.
  - The FSM returns to IDLE.
- BUS_Ack sampled while in IDLE is ignored.
- A granted transaction always completes, even if the requester drops its Req after the grant (for example on a pipeline flush). Ready still pulses; the requester discards it.
- There is no timeout; a bus that never acknowledges stalls the core indefinitely.

## Timing
- Reset values: FSM = IDLE; BUS_Req = 0; BUS fields = 0; IF_Ready = DM_Ready = 0; IF_Data = DM_R_Data = 0; Stall_Count = 0.
- Request seen in IDLE in cycle 0 → BUS_Req high in cycle 1 → BUS_Ack in cycle k≥1 → Ready high in cycle k+1.
- Minimum latency from Req to Ready is 2 cycles, with zero-wait memory.
- Back-to-back accesses: while Ready pulses for one port, IDLE may grant the other port in the same cycle. The bus is then re-requested in the following cycle, so at most one bus-idle cycle occurs between accesses.
- Simultaneous IF_Req and DM_Req in IDLE: DM is served first. IF is granted in the DM_Ready cycle, so it reaches the bus one cycle later.
- Stall_F and Stall_M are low in the Ready cycle. This lets the pipeline advance on that edge.
- Stall_Count increments at each edge where Stall_F | Stall_M was high.
- Asynchronous RST mid-transaction:
  - All state and outputs immediately take their reset values.
  - The outstanding bus access is abandoned.
  - A late BUS_Ack after reset is ignored.

## Structure
- core_pkg holds:
  - the typedef enum arb_state_t {IDLE, IF_BUSY, DM_BUSY};
  - a localparam for the byte-enable width.
- Sub-module: stall_counter, a 32-bit wrapping counter with enable, CLK and RST, instantiated once for Stall_Count.
- All other logic lives in mem_arbiter.

## Test plan
- Zero-wait fetch: IF_Req=1, IF_Addr=0x100, BUS_Ack tied to BUS_Req, BUS_R_Data=0x00000013 → BUS_Addr=0x100 in cycle 1, IF_Ready and IF_Data=0x13 in cycle 2, Stall_F high in cycles 0–1, Stall_Count=2.
- Collision: IF_Req and DM_Req (load, 0x2000) rise together, memory has 3-cycle latency → DM is served first; the IF access reaches the bus in the DM_Ready cycle+1; IF_Ready follows 4 cycles after DM_Ready.
- Store: DM_W_En=1, DM_Addr=0x40, DM_W_Data=0xDEADBEEF, DM_Byte_En=4'b0011 → bus fields match and are held stable through 2 wait cycles; DM_Ready pulses once; DM_R_Data is unchanged.
- Flush after grant: IF_Req drops in the cycle after the grant → the bus access completes and IF_Ready pulses once; no second bus request is issued.
- Reset mid-access: RST asserted in a BUSY state before BUS_Ack → BUS_Req=0 within the same cycle and the FSM is in IDLE; a BUS_Ack one cycle later produces no Ready.
- Counter wrap: force the count to 0xFFFFFFFF and stall for 1 cycle → Stall_Count=0.
